parity_frame_ctrl: RTL and testbench
====================================

# parity_frame_ctrl

Serial even-parity frame controller that sequences the even-parity check over a bit stream. Each frame is a one-cycle `start` strobe, then DATA_W data bits and one parity bit, each qualified by `sin_valid`. The block deserialises the frame, applies the even-parity check (out_ok = XNOR of all data bits and the parity bit) and presents the result on a valid/ready output port. It sits between a serial link front end and the consumer of checked words, and tracks parity errors.

## Interface
- DATA_W, 3: data bits per frame, excluding parity; legal range 1..32.
- CNT_W, 8: width of the error counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame-start strobe; honoured only in IDLE, or in DONE on a completing handshake.
- sin  in  1  serial data/parity bit; data bits arrive MSB first.
- sin_valid  in  1  qualifies `sin`; `sin` is sampled only in SHIFT with `sin_valid`=1.
- busy  out  1  high when state is not IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  received data bits.
- out_ok  out  1  1 = even parity satisfied (total count of ones is even); 0 = parity error.
- err_sticky  out  1  set by any frame with out_ok=0; cleared only by err_clr or rst.
- err_clr  in  1  clears err_sticky and err_cnt.
- err_cnt  out  CNT_W  saturating parity-error count. Present only with PARITY_ERR_CNT_EN.

## Operation
- **States:** IDLE, SHIFT, DONE. Encoding is free.
- **IDLE:**
  - start=1 -> SHIFT.
  - The bit counter and shift register are cleared.
  - `sin` is not sampled in the start cycle.
- **SHIFT:**
  - Each cycle with sin_valid=1 samples one bit.
  - The first DATA_W bits shift into the data register MSB first.
  - Bit DATA_W+1 is the parity bit. At the edge that samples it:
    - out_data is loaded.
    - out_ok = ~^{data, parity}.
    - out_valid <= 1 and the state moves to DONE.
  - sin_valid=0 cycles stall with no state change. Gaps of any length are legal.
  - start during SHIFT is ignored and does not restart the frame.
- **DONE:**
  - out_valid, out_data and out_ok hold stable until out_valid and out_ready are both 1.
  - On the handshake, out_valid <= 0 and the state moves to IDLE.
  - If start=1 in the same cycle as the handshake, the state moves directly to SHIFT (back-to-back frames).
  - `sin` is ignored in DONE.
- **Error tracking:**
  - At the edge that loads a result with out_ok=0:
    - err_sticky <= 1.
    - err_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - err_clr in the same cycle as a new error: the error wins, giving err_sticky=1 and err_cnt=1.
  - err_clr otherwise: err_sticky=0 and err_cnt=0 at the next edge.
- **Reset:**
  - rst=1 at any edge gives state IDLE, busy=0, out_valid=0, out_data=0, out_ok=0, err_sticky=0, err_cnt=0.
  - A partially received frame is discarded.
  - rst has priority over all other inputs.

## Timing
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Frame latency:**
  - With start sampled at edge k and contiguous sin_valid, data bits are sampled at edges k+1..k+DATA_W.
  - The parity bit is sampled at edge k+DATA_W+1.
  - out_valid is high from edge k+DATA_W+1.
- **Throughput:** one frame per DATA_W+2 cycles, using back-to-back start with out_ready held at 1.
- **busy:** rises at the edge after start is accepted; falls at the handshake edge unless a back-to-back start is taken.

## Configuration
- Macro: PARITY_ERR_CNT_EN.
- **Defined:** port err_cnt[CNT_W-1:0] and the saturating counter exist as described above.
- **Undefined:**
  - The err_cnt port and the counter logic are absent.
  - err_sticky behaviour is unchanged.
  - CNT_W is accepted but unused.

## Test plan
All scenarios use DATA_W=3.
- **Good frame:** start, then bits 0,1,1 with parity 0, out_ready=1 -> out_valid for one cycle at edge k+4, out_data=3'b011, out_ok=1, err_sticky=0, err_cnt=0.
- **Bad frame with stalls:** bits 1,1,0 with parity 1, and sin_valid low for 2 cycles between bits -> out_data=3'b110, out_ok=0, err_sticky=1, err_cnt=1. out_valid rises 2 cycles later than in the no-stall case.
- **Backpressure and back-to-back:**
  - Frame 1,1,1 with parity 1, out_ready=0 for 5 cycles -> outputs hold stable (out_ok=1) and start during the hold is ignored.
  - out_ready=1 together with start -> the state goes straight to SHIFT, and the next frame completes DATA_W+1 cycles later.
- **Reset mid-frame:** rst after 2 data bits -> all outputs 0, state IDLE. A following good frame 0,1,1 with parity 0 produces out_ok=1 with no residue.
- **Saturation and clear:**
  - CNT_W=2, five bad frames -> err_cnt=3.
  - err_clr alone -> err_cnt=0, err_sticky=0.
  - err_clr coincident with a bad-frame result -> err_cnt=1, err_sticky=1.
- **Macro off:** build without PARITY_ERR_CNT_EN and rerun the bad-frame scenario -> err_sticky=1, the err_cnt port is absent, and elaboration is clean.

Source files
------------

// File: rtl/parity_frame_ctrl.sv
// Serial even-parity frame deserialiser with valid/ready result port and error tracking.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
module parity_frame_ctrl #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sin,
  input  logic              sin_valid,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ok,
  output logic              err_sticky,
  input  logic              err_clr
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int unsigned CntBits = $clog2(DATA_W + 2);

  if (DATA_W < 1 || DATA_W > 32 || CNT_W < 1) begin : g_bad_param
    $error("parity_frame_ctrl: illegal DATA_W or CNT_W");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntBits-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_ok_q, out_ok_d;
  logic                err_sticky_q, err_sticky_d;
  logic                err_new;
  logic                handshake;

  assign handshake = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ok_d    = out_ok_q;
    err_new     = 1'b0;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        if (start) state_d = StShift;
      end
      StShift: begin
        if (sin_valid) begin
          if (bit_cnt_q == CntBits'(DATA_W)) begin
            // This is the parity bit: publish the word and its check result.
            out_data_d  = shift_q;
            out_ok_d    = ~^{shift_q, sin};
            err_new     = ^{shift_q, sin};
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            shift_d   = DATA_W'({shift_q, sin});
            bit_cnt_d = bit_cnt_q + CntBits'(1);
          end
        end
      end
      StDone: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          bit_cnt_d   = '0;
          shift_d     = '0;
          state_d     = start ? StShift : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);

    // A new error outranks a simultaneous clear.
    err_sticky_d = err_sticky_q;
    if (err_new) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_new) begin
      if (err_clr) begin
        err_cnt_d = CNT_W'(1);
      end else if (err_cnt_q != {CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ok_q     <= 1'b0;
      err_sticky_q <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ok_q     <= out_ok_d;
      err_sticky_q <= err_sticky_d;
`ifdef PARITY_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ok     = out_ok_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed table-driven bench for parity_frame_ctrl (DATA_W=3, CNT_W=2).
// err_cnt checks are active only when PARITY_ERR_CNT_EN is defined.
module tb_parity_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sin = 1'b0;
  logic       sin_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy;
  logic       out_valid;
  logic [2:0] out_data;
  logic       out_ok;
  logic       err_sticky;
`ifdef PARITY_ERR_CNT_EN
  logic [1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl #(
    .DATA_W(3),
    .CNT_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ok    (out_ok),
    .err_sticky(err_sticky),
    .err_clr   (err_clr)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic       rst, start, sv, sin, rdy, clr;
    logic       busy, vld;
    logic [2:0] data;
    logic       ok, st;
    logic [1:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic s, logic v, logic b, logic y, logic c,
                              logic eb, logic ev, logic [2:0] ed, logic eo, logic es,
                              logic [1:0] ec);
    vec_t t;
    t.rst = r; t.start = s; t.sv = v; t.sin = b; t.rdy = y; t.clr = c;
    t.busy = eb; t.vld = ev; t.data = ed; t.ok = eo; t.st = es; t.cnt = ec;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(string name, logic [1:0] exp);
`ifdef PARITY_ERR_CNT_EN
    chk(name, {30'd0, err_cnt}, {30'd0, exp});
`endif
  endtask

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic step(logic r, logic s, logic v, logic b, logic y, logic c);
    rst = r; start = s; sin_valid = v; sin = b; out_ready = y; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic eb, logic ev, logic [2:0] ed, logic eo, logic es,
                         logic [1:0] ec);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, " out_data"}, {29'd0, out_data}, {29'd0, ed});
    chk({tag, " out_ok"}, {31'd0, out_ok}, {31'd0, eo});
    chk({tag, " err_sticky"}, {31'd0, err_sticky}, {31'd0, es});
    chk_cnt({tag, " err_cnt"}, ec);
  endtask

  // Bad frame 1,1,0 parity 1; err_clr optionally asserted on the parity edge.
  task automatic bad_frame(string tag, logic clr_at_parity, logic [1:0] exp_cnt);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, clr_at_parity);
    chk_all(tag, 1, 1, 3'b110, 0, 1, exp_cnt);
    step(0, 0, 0, 0, 1, 0);
    chk({tag, " drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, good frame, stalled bad frame, backpressure and back-to-back.
    vq.push_back(mk(1,0,0,0,0,0, 0,0,3'b000,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0, 1,0,3'b000,0,0,0));
    vq.push_back(mk(0,0,1,0,1,0, 1,0,3'b000,0,0,0));
    vq.push_back(mk(0,0,1,1,1,0, 1,0,3'b000,0,0,0));
    vq.push_back(mk(0,0,1,1,1,0, 1,0,3'b000,0,0,0));
    vq.push_back(mk(0,0,1,0,1,0, 1,1,3'b011,1,0,0));
    vq.push_back(mk(0,0,0,0,1,0, 0,0,3'b011,1,0,0));
    vq.push_back(mk(0,1,0,0,0,0, 1,0,3'b011,1,0,0));
    vq.push_back(mk(0,0,1,1,0,0, 1,0,3'b011,1,0,0));
    vq.push_back(mk(0,0,0,1,0,0, 1,0,3'b011,1,0,0));
    vq.push_back(mk(0,0,0,1,0,0, 1,0,3'b011,1,0,0));
    vq.push_back(mk(0,0,1,1,0,0, 1,0,3'b011,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0, 1,0,3'b011,1,0,0));
    vq.push_back(mk(0,0,1,1,0,0, 1,1,3'b110,0,1,1));
    vq.push_back(mk(0,0,0,0,1,0, 0,0,3'b110,0,1,1));
    vq.push_back(mk(0,1,0,0,0,0, 1,0,3'b110,0,1,1));
    vq.push_back(mk(0,0,1,1,0,0, 1,0,3'b110,0,1,1));
    vq.push_back(mk(0,0,1,1,0,0, 1,0,3'b110,0,1,1));
    vq.push_back(mk(0,0,1,1,0,0, 1,0,3'b110,0,1,1));
    vq.push_back(mk(0,0,1,1,0,0, 1,1,3'b111,1,1,1));
    vq.push_back(mk(0,1,1,0,0,0, 1,1,3'b111,1,1,1));
    vq.push_back(mk(0,0,1,1,0,0, 1,1,3'b111,1,1,1));
    vq.push_back(mk(0,1,0,0,0,0, 1,1,3'b111,1,1,1));
    vq.push_back(mk(0,0,0,0,0,0, 1,1,3'b111,1,1,1));
    vq.push_back(mk(0,1,1,1,0,0, 1,1,3'b111,1,1,1));
    vq.push_back(mk(0,1,0,0,1,0, 1,0,3'b111,1,1,1));
    vq.push_back(mk(0,0,1,0,1,0, 1,0,3'b111,1,1,1));
    vq.push_back(mk(0,1,1,1,1,0, 1,0,3'b111,1,1,1));
    vq.push_back(mk(0,0,1,1,1,0, 1,0,3'b111,1,1,1));
    vq.push_back(mk(0,0,1,0,1,0, 1,1,3'b011,1,1,1));
    vq.push_back(mk(0,0,0,0,1,0, 0,0,3'b011,1,1,1));

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].start, vq[i].sv, vq[i].sin, vq[i].rdy, vq[i].clr);
      chk_all($sformatf("v%0d", i), vq[i].busy, vq[i].vld, vq[i].data, vq[i].ok, vq[i].st,
              vq[i].cnt);
    end

    // Reset in the middle of a frame, then a clean good frame.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    chk_all("midrst", 0, 0, 3'b000, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("midrst early", {31'd0, out_valid}, 32'd0);
    step(0, 0, 1, 0, 1, 0);
    chk_all("postrst", 1, 1, 3'b011, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk_all("postrst hs", 0, 0, 3'b011, 1, 0, 0);

    // Saturating counter, standalone clear, clear colliding with a new error.
    for (int i = 1; i <= 5; i++) begin
      bad_frame($sformatf("sat%0d", i), 1'b0, (i > 3) ? 2'd3 : 2'(i));
    end
    step(0, 0, 0, 0, 0, 1);
    chk_all("clr", 0, 0, 3'b110, 0, 0, 0);
    bad_frame("clr+err", 1'b1, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
